// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer driving one shared external full adder, LSB first.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, res_sum_q, res_sum_d;
  logic             carry_q, carry_d, res_cout_q, res_cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    unique case (state_q)
      IDLE: if (start_valid) begin
        a_d     = op_a;
        b_d     = op_b;
        carry_d = cin;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        // last bit: the freshly shifted sum is the complete result
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_sum_d  = sum_d;
          res_cout_d = fa_cout;
          state_d    = DONE;
        end
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign start_ready = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign res_valid   = state_q == DONE;
  assign fa_a        = state_q == RUN ? a_q[0] : 1'b0;
  assign fa_b        = state_q == RUN ? b_q[0] : 1'b0;
  assign fa_cin      = state_q == RUN ? carry_q : 1'b0;
  assign res_sum     = res_sum_q;
  assign res_cout    = res_cout_q;
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add sequencer that time-shares one external 1-bit full adder across a WIDTH-bit addition. It accepts an operand pair through a valid/ready start handshake and feeds the adder one bit pair per cycle, LSB first, with the carry registered between cycles. It then presents the WIDTH-bit sum and carry-out through a valid/ready result handshake. It sits between the SPU operand source and the shared adder cell, trading latency for area.

## Interface

- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  operand pair offered.
- start_ready  out  1  block can accept operands; high only in IDLE.
- op_a  in  WIDTH  addend A; sampled on accept only.
- op_b  in  WIDTH  addend B; sampled on accept only.
- cin  in  1  carry-in; sampled on accept only.
- fa_a  out  1  bit to adder input a.
- fa_b  out  1  bit to adder input b.
- fa_cin  out  1  carry to adder carry input.
- fa_sum  in  1  adder sum; combinational from fa_*.
- fa_cout  in  1  adder carry-out; combinational from fa_*.
- res_valid  out  1  result available; high only in DONE.
- res_ready  in  1  consumer takes result.
- res_sum  out  WIDTH  registered sum.
- res_cout  out  1  registered final carry.
- busy  out  1  high in RUN or DONE.

## Operation

- State machine: IDLE, RUN, DONE. Encoding is free.
- Internal registers: a_sh, b_sh, sum_sh (WIDTH each), carry (1), bit counter cnt (clog2(WIDTH) bits).
- IDLE:
  - Outputs: start_ready=1, busy=0, fa_a=fa_b=fa_cin=0.
  - On start_valid&&start_ready: a_sh<=op_a, b_sh<=op_b, carry<=cin, cnt<=0, go to RUN.
- RUN:
  - Drives fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry.
  - Each edge: a_sh and b_sh shift right by 1, sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}, carry<=fa_cout, cnt<=cnt+1.
  - When cnt==WIDTH-1: also res_sum<={fa_sum, sum_sh[WIDTH-1:1]}, res_cout<=fa_cout, go to DONE.
- DONE:
  - Outputs: res_valid=1, fa_*=0.
  - On res_ready: go to IDLE. Otherwise hold indefinitely.
- res_sum and res_cout change only on the RUN→DONE edge. They keep their last value after DONE until the next completion.
- Ignored inputs:
  - start_valid outside IDLE is not accepted; operands are not re-sampled.
  - res_ready outside DONE has no effect.
- Arithmetic: {res_cout,res_sum} = op_a + op_b + cin, exact for all inputs. No overflow flag.

## Timing

- Accept edge = edge 0, which enters RUN.
- RUN occupies exactly WIDTH cycles. Bit i is presented on fa_* in cycle i after accept.
- res_valid rises after edge WIDTH, so latency from accept to result is WIDTH cycles.
- DONE lasts at least 1 cycle. Result transfer happens on the edge where res_valid&&res_ready.
- IDLE lasts at least 1 cycle, so there is no DONE→RUN bypass.
- Minimum accept-to-accept period is WIDTH+2 cycles (10 for WIDTH=8).
- Reset (rst_n low, any state, any time):
  - State→IDLE; all internal registers and res_sum, res_cout → 0.
  - res_valid=0, busy=0, fa_*=0.
  - start_ready reads 1, but no accept occurs while rst_n is low.
  - An in-flight operation is discarded with no partial result.
- Reset release: first accept possible on the first rising edge with rst_n high.
- fa_sum and fa_cout must settle within one cycle. The block adds no registers on the adder path.

## Test plan

All scenarios use WIDTH=8 with a behavioural full adder connected to fa_*.

- Power-up: rst_n low 3 cycles → res_valid=0, busy=0, start_ready=1, res_sum=8'h00, res_cout=0, fa_*=0.
- No-carry add: 8'h35+8'h4A, cin=0, res_ready=1 → res_valid exactly 8 cycles after accept, res_sum=8'h4A+8'h35=8'h7F, res_cout=0. fa_a sequence over RUN is 1,0,1,0,1,1,0,0.
- Full ripple carry:
  - 8'hFF+8'h01, cin=0 → res_sum=8'h00, res_cout=1.
  - 8'hFF+8'hFF, cin=1 → res_sum=8'hFF, res_cout=1.
- Backpressure:
  - res_ready low 5 cycles after res_valid → res_valid and res_sum stay stable. start_valid held high with new operands is not accepted during RUN/DONE.
  - After res_ready=1, the next op is accepted exactly 2 edges later; accept-to-accept is 10 cycles.
- Reset mid-operation: 8'hAA+8'h55 accepted, rst_n pulsed low after 3 RUN cycles → immediate IDLE, res_sum=8'h00, res_valid=0, busy=0. The following op 8'h12+8'h34, cin=1 gives res_sum=8'h47, res_cout=0.
- Back-to-back stream: 4 random operand sets with start_valid and res_ready held high → 4 correct results in order, each compared against a+b+cin.
